// File: rtl/mips_single_cycle_pkg.sv
// mips_single_cycle_pkg: opcodes, ALU control encoding, memory depths and the self-check program
package mips_single_cycle_pkg;
  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;
  localparam int PROG_LEN = 18;
  localparam logic [31:0] PROG [PROG_LEN] = '{
    32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025, 32'h00642824, 32'h00a42820,
    32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h20050000, 32'h00e2202a, 32'h00853820,
    32'h00e23822, 32'hac670044, 32'h8c020050, 32'h08000011, 32'h20020001, 32'hac020054
  };
endpackage

// File: rtl/mips_single_cycle_core.sv
// mips_single_cycle_core: controller, register file, ALU and next-PC logic of the single-cycle core
module mips_single_cycle_core
  import mips_single_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] o_pc,
  input  logic [31:0] i_instr,
  output logic        o_memwrite,
  output logic [31:0] o_aluout,
  output logic [31:0] o_writedata,
  input  logic [31:0] i_readdata
);
  logic [31:0] r_pc;
  logic [31:0] r_rf [32];
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_wa;
  logic [31:0] w_simm, w_a, w_b, w_rtv, w_pc4, w_alu;
  logic        w_rtype, w_lw, w_sw, w_beq, w_addi, w_j, w_regwrite;
  alu_ctl_e    w_ctl;
  logic        w_unused;
  assign w_op     = i_instr[31:26];
  assign w_rs     = i_instr[25:21];
  assign w_rt     = i_instr[20:16];
  assign w_rd     = i_instr[15:11];
  assign w_funct  = i_instr[5:0];
  assign w_unused = ^i_instr[10:6];
  assign w_simm   = {{16{i_instr[15]}}, i_instr[15:0]};
  // unsupported functs (including the all-zero sll word) fall through as NOPs
  assign w_rtype  = w_op == OP_RTYPE && (w_funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
  assign w_lw     = w_op == OP_LW;
  assign w_sw     = w_op == OP_SW;
  assign w_beq    = w_op == OP_BEQ;
  assign w_addi   = w_op == OP_ADDI;
  assign w_j      = w_op == OP_J;
  assign w_regwrite = (w_rtype | w_addi | w_lw) & ~reset;
  assign w_wa     = w_rtype ? w_rd : w_rt;
  assign w_a      = w_rs == 5'd0 ? 32'd0 : r_rf[w_rs];
  assign w_rtv    = w_rt == 5'd0 ? 32'd0 : r_rf[w_rt];
  assign w_b      = w_rtype ? w_rtv : w_simm;
  assign w_ctl    = !w_rtype ? ALU_ADD :
                    w_funct == F_SUB ? ALU_SUB :
                    w_funct == F_AND ? ALU_AND :
                    w_funct == F_OR  ? ALU_OR  :
                    w_funct == F_SLT ? ALU_SLT : ALU_ADD;
  assign w_alu    = w_ctl == ALU_AND ? w_a & w_b :
                    w_ctl == ALU_OR  ? w_a | w_b :
                    w_ctl == ALU_SUB ? w_a - w_b :
                    w_ctl == ALU_SLT ? {31'd0, $signed(w_a) < $signed(w_b)} : w_a + w_b;
  assign w_pc4    = r_pc + 32'd4;
  always_ff @(posedge clk) begin
    r_pc <= reset ? 32'd0 :
            (w_beq && w_a == w_rtv) ? w_pc4 + {w_simm[29:0], 2'b00} :
            w_j ? {w_pc4[31:28], i_instr[25:0], 2'b00} : w_pc4;
    if (w_regwrite && w_wa != 5'd0) r_rf[w_wa] <= w_lw ? i_readdata : w_alu;
  end
  assign o_pc        = r_pc;
  assign o_memwrite  = w_sw & ~reset;
  assign o_aluout    = w_alu;
  assign o_writedata = w_rtv;
endmodule

// File: rtl/mips_single_cycle_top.sv
// mips_single_cycle_top: single-cycle MIPS core with program ROM and data RAM
module mips_single_cycle_top
  import mips_single_cycle_pkg::*;
#(
  parameter int IMEM_WORDS = mips_single_cycle_pkg::IMEM_WORDS,
  parameter int DMEM_WORDS = mips_single_cycle_pkg::DMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  logic [31:0] w_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];
  logic [31:0] w_pc, w_instr, w_readdata;
  logic        w_unused;
  for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
    if (g < PROG_LEN) begin : g_prog
      assign w_imem[g] = PROG[g];
    end else begin : g_zero
      assign w_imem[g] = 32'd0;
    end
  end
  assign w_instr    = w_imem[w_pc[IW+1:2]];
  assign w_readdata = r_dmem[dataadr[DW+1:2]];
  assign w_unused   = ^{w_pc[31:IW+2], w_pc[1:0], dataadr[31:DW+2], dataadr[1:0]};
  always_ff @(posedge clk) begin
    if (memwrite) r_dmem[dataadr[DW+1:2]] <= writedata;
  end
  mips_single_cycle_core u_core (
    .clk         (clk),
    .reset       (reset),
    .o_pc        (w_pc),
    .i_instr     (w_instr),
    .o_memwrite  (memwrite),
    .o_aluout    (dataadr),
    .o_writedata (writedata),
    .i_readdata  (w_readdata)
  );
endmodule

// File: tb/tb_mips_single_cycle_top.sv
// tb_mips_single_cycle_top: scoreboard bench checking the store stream and final architectural state
module tb_mips_single_cycle_top;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] writedata, dataadr;
  logic        memwrite;
  typedef struct { int cyc; logic [31:0] adr; logic [31:0] dat; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit bad_pc = 0, bad_reg = 0;

  mips_single_cycle_top dut (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .dataadr   (dataadr),
    .memwrite  (memwrite)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: samples on the falling edge, pops the scoreboard on every store
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      cyc = 0;
      check("memwrite_in_reset", {31'd0, memwrite}, 32'd0);
    end else begin
      cyc++;
      if (cyc == 1) check("pc_after_reset", dut.w_pc, 32'd0);
      if (dut.w_pc == 32'd36 || dut.w_pc == 32'd64) bad_pc = 1;
      if (cyc >= 7 && dut.u_core.r_rf[5] == 32'd0) bad_reg = 1;
      if (cyc >= 16 && cyc <= 40 && dut.u_core.r_rf[2] == 32'd1) bad_reg = 1;
      if (memwrite) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_store: cycle %0d adr %0h data %0h, none expected", cyc, dataadr, writedata);
        end else begin
          e = q.pop_front();
          check("store_cycle", cyc, e.cyc);
          check("store_adr", dataadr, e.adr);
          check("store_data", writedata, e.dat);
        end
      end
    end
  end

  task automatic push_stores();
    q.push_back('{cyc: 13, adr: 32'd80, dat: 32'd7});
    q.push_back('{cyc: 16, adr: 32'd84, dat: 32'd7});
  endtask

  task automatic wait_empty(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL store_timeout: %0d stores still pending", q.size());
    q.delete();
  endtask

  task automatic wait_cyc(input int n, input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      #1;
      if (cyc >= n) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL cycle_timeout: cycle %0d required %0d", cyc, n);
  endtask

  task automatic check_state();
    check("reg0", dut.u_core.r_rf[0], 32'd0);
    check("reg2", dut.u_core.r_rf[2], 32'd7);
    check("reg3", dut.u_core.r_rf[3], 32'd12);
    check("reg4", dut.u_core.r_rf[4], 32'd1);
    check("reg5", dut.u_core.r_rf[5], 32'd11);
    check("reg7", dut.u_core.r_rf[7], 32'd7);
    check("ram20", dut.r_dmem[20], 32'd7);
    check("ram21", dut.r_dmem[21], 32'd7);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push_stores();
    wait_empty(60);
    repeat (10) @(posedge clk);
    #1 check_state();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_cyc(5, 20);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    push_stores();
    wait_empty(60);
    repeat (10) @(posedge clk);
    #1 check_state();
    check("skipped_words_committed", {31'd0, bad_pc}, 32'd0);
    check("reg_after_branch_or_lw", {31'd0, bad_reg}, 32'd0);
    check("pending_stores", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
